// File: rtl/ps2_receiver.sv
// ps2_receiver: PS/2 frame decoder with an 8-bit byte FIFO and
// gap-paced one-cycle delivery pulses for the keyboard display FSM.
module ps2_receiver #(
  parameter int FIFO_AW     = 3,
  parameter int GAP_CYC     = 4,
  parameter int TIMEOUT_CYC = 20000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic [7:0] ps2dis_data,
  output logic       ps2dis_recFlag,
  output logic       overflow,
  output logic       frame_err,
  output logic [7:0] err_cnt
);

  localparam int DEPTH = 1 << FIFO_AW;
  localparam int GW = (GAP_CYC > 1) ? $clog2(GAP_CYC) : 1;
  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  localparam logic [GW-1:0] GAP_LD = GW'(GAP_CYC - 1);
  localparam logic [TW-1:0] TO_MAX = TW'(TIMEOUT_CYC);

  logic              kc1_q, kc1_d;
  logic              kc2_q, kc2_d;
  logic              kch_q, kch_d;
  logic              kd1_q, kd1_d;
  logic              kd2_q, kd2_d;

  logic [3:0]        bit_q, bit_d;
  logic [7:0]        sh_q, sh_d;
  logic              par_q, par_d;
  logic [TW-1:0]     to_q, to_d;

  logic [7:0]        mem_q [DEPTH];
  logic [7:0]        mem_d [DEPTH];
  logic [FIFO_AW:0]  wp_q, wp_d;
  logic [FIFO_AW:0]  rp_q, rp_d;
  logic [GW-1:0]     gap_q, gap_d;

  logic [7:0]        data_q, data_d;
  logic              rec_q, rec_d;
  logic              ovf_q, ovf_d;
  logic              ferr_q, ferr_d;
  logic [7:0]        errc_q, errc_d;

  logic              fall;
  logic              good;
  logic              bad;
  logic              empty;
  logic              full;
  logic              push_ok;
  logic              pop;

  assign fall  = kch_q & ~kc2_q;
  assign empty = (wp_q == rp_q);
  assign full  = (wp_q[FIFO_AW] != rp_q[FIFO_AW]) &&
                 (wp_q[FIFO_AW-1:0] == rp_q[FIFO_AW-1:0]);

  // Frame capture and timeout supervision
  always_comb begin
    kc1_d = ps2_clk;
    kc2_d = kc1_q;
    kch_d = kc2_q;
    kd1_d = ps2_data;
    kd2_d = kd1_q;
    bit_d = bit_q;
    sh_d  = sh_q;
    par_d = par_q;
    to_d  = to_q;
    good  = 1'b0;
    bad   = 1'b0;
    if (fall) begin
      to_d = '0;
      unique case (1'b1)
        (bit_q == 4'd0): begin
          if (!kd2_q) bit_d = 4'd1;
        end
        (bit_q inside {[4'd1:4'd8]}): begin
          sh_d  = {kd2_q, sh_q[7:1]};
          bit_d = bit_q + 4'd1;
        end
        (bit_q == 4'd9): begin
          par_d = kd2_q;
          bit_d = 4'd10;
        end
        default: begin
          bit_d = '0;
          if (kd2_q && (^{sh_q, par_q})) good = 1'b1;
          else bad = 1'b1;
        end
      endcase
    end else if (bit_q != 4'd0) begin
      if (to_q == TO_MAX) begin
        bad   = 1'b1;
        bit_d = '0;
        to_d  = '0;
      end else begin
        to_d = to_q + TW'(1);
      end
    end else begin
      to_d = '0;
    end
  end

  // FIFO, pacing and status; full is judged before any pop
  always_comb begin
    mem_d   = mem_q;
    wp_d    = wp_q;
    rp_d    = rp_q;
    gap_d   = gap_q;
    data_d  = data_q;
    rec_d   = 1'b0;
    push_ok = good & ~full;
    pop     = ~empty & (gap_q == '0);
    ovf_d   = ovf_q | (good & full);
    ferr_d  = bad;
    errc_d  = errc_q;
    if (push_ok) begin
      mem_d[wp_q[FIFO_AW-1:0]] = sh_q;
      wp_d = wp_q + 1'b1;
    end
    if (pop) begin
      data_d = mem_q[rp_q[FIFO_AW-1:0]];
      rec_d  = 1'b1;
      rp_d   = rp_q + 1'b1;
      gap_d  = GAP_LD;
    end else if (gap_q != '0) begin
      gap_d = gap_q - GW'(1);
    end
    if (bad && errc_q != 8'hFF) errc_d = errc_q + 8'd1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      kc1_q  <= 1'b1;
      kc2_q  <= 1'b1;
      kch_q  <= 1'b1;
      kd1_q  <= 1'b1;
      kd2_q  <= 1'b1;
      bit_q  <= '0;
      sh_q   <= '0;
      par_q  <= 1'b0;
      to_q   <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wp_q   <= '0;
      rp_q   <= '0;
      gap_q  <= '0;
      data_q <= '0;
      rec_q  <= 1'b0;
      ovf_q  <= 1'b0;
      ferr_q <= 1'b0;
      errc_q <= '0;
    end else begin
      kc1_q  <= kc1_d;
      kc2_q  <= kc2_d;
      kch_q  <= kch_d;
      kd1_q  <= kd1_d;
      kd2_q  <= kd2_d;
      bit_q  <= bit_d;
      sh_q   <= sh_d;
      par_q  <= par_d;
      to_q   <= to_d;
      mem_q  <= mem_d;
      wp_q   <= wp_d;
      rp_q   <= rp_d;
      gap_q  <= gap_d;
      data_q <= data_d;
      rec_q  <= rec_d;
      ovf_q  <= ovf_d;
      ferr_q <= ferr_d;
      errc_q <= errc_d;
    end
  end

  assign ps2dis_data    = data_q;
  assign ps2dis_recFlag = rec_q;
  assign overflow       = ovf_q;
  assign frame_err      = ferr_q;
  assign err_cnt        = errc_q;

endmodule

// File: tb/tb_ps2_receiver.sv
// tb_ps2_receiver: directed PS/2 frames against a queue model of
// delivered bytes, pacing, latency and error counting.
module tb_ps2_receiver;

  localparam int GAP = 2000;
  localparam int TMO = 500;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       ps2_clk = 1'b1;
  logic       ps2_data = 1'b1;
  logic [7:0] ps2dis_data;
  logic       ps2dis_recFlag;
  logic       overflow;
  logic       frame_err;
  logic [7:0] err_cnt;

  ps2_receiver #(
    .FIFO_AW(3),
    .GAP_CYC(GAP),
    .TIMEOUT_CYC(TMO)
  ) dut (
    .clk(clk),
    .rst(rst_n),
    .ps2_clk(ps2_clk),
    .ps2_data(ps2_data),
    .ps2dis_data(ps2dis_data),
    .ps2dis_recFlag(ps2dis_recFlag),
    .overflow(overflow),
    .frame_err(frame_err),
    .err_cnt(err_cnt)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  int errors = 0;
  int checks = 0;

  logic [7:0] mq[$];
  logic [7:0] m_last = 8'h00;
  bit         m_ovf = 1'b0;
  int         err_exp = 0;
  int         pulses = 0;
  int         ferrs = 0;
  int         fall_cyc = 0;
  int         prev_pc = 0;
  bit         have_prev = 1'b0;
  bit         lat_chk = 1'b0;
  bit         prev_rec = 1'b0;
  bit         prev_ferr = 1'b0;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Per-cycle compare against the model
  always @(negedge clk) begin
    if (!rst_n) begin
      have_prev = 1'b0;
      prev_rec  = 1'b0;
      prev_ferr = 1'b0;
      ferrs     = 0;
    end else begin
      if (ps2dis_recFlag) begin
        pulses++;
        checks++;
        if (prev_rec || mq.size() == 0) begin
          errors++;
          $display("FAIL pulse: unexpected recFlag data=%0h queued=%0d",
                   ps2dis_data, mq.size());
        end else begin
          m_last = mq.pop_front();
        end
        if (have_prev) begin
          checks++;
          if (cyc - prev_pc < GAP) begin
            errors++;
            $display("FAIL gap: got %0d cycles required >= %0d",
                     cyc - prev_pc, GAP);
          end
        end
        have_prev = 1'b1;
        prev_pc   = cyc;
        if (lat_chk) begin
          lat_chk = 1'b0;
          checks++;
          if (cyc - fall_cyc != 4) begin
            errors++;
            $display("FAIL latency: got %0d expected 4", cyc - fall_cyc);
          end
        end
      end
      checks++;
      if (ps2dis_data !== m_last) begin
        errors++;
        $display("FAIL data: got %0h expected %0h", ps2dis_data, m_last);
      end
      if (frame_err) begin
        ferrs++;
        checks++;
        if (prev_ferr) begin
          errors++;
          $display("FAIL ferr_width: got 2+ cycles expected 1");
        end
      end
      prev_rec  = ps2dis_recFlag;
      prev_ferr = frame_err;
    end
  end

  task automatic wait_cyc(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic send_frame(input logic [7:0] b, input bit bad_par,
                            input int nbits);
    logic [10:0] f;
    f = {1'b1, (~^b) ^ bad_par, b, 1'b0};
    for (int i = 0; i < nbits; i++) begin
      ps2_data = f[i];
      wait_cyc(2);
      ps2_clk = 1'b0;
      if (i == 10) begin
        fall_cyc = cyc;
        if (!bad_par) begin
          if (mq.size() >= 8) m_ovf = 1'b1;
          else mq.push_back(b);
        end
      end
      wait_cyc(4);
      ps2_clk = 1'b1;
      wait_cyc(2);
    end
    ps2_data = 1'b1;
  endtask

  initial begin
    wait_cyc(3);
    chk("rst_data", ps2dis_data, 8'h00);
    chk("rst_flag", ps2dis_recFlag, 1'b0);
    chk("rst_ovf", overflow, 1'b0);
    chk("rst_ferr", frame_err, 1'b0);
    chk("rst_errcnt", err_cnt, 8'h00);
    rst_n = 1'b1;
    wait_cyc(5);

    lat_chk = 1'b1;
    send_frame(8'h1C, 1'b0, 11);
    wait_cyc(50);
    chk("t1_pulses", pulses, 1);
    chk("t1_data", ps2dis_data, 8'h1C);
    chk("t1_ferrs", ferrs, 0);
    chk("t1_errcnt", err_cnt, 8'h00);
    chk("t1_latdone", lat_chk, 1'b0);
    wait_cyc(GAP + 100);

    send_frame(8'hF0, 1'b0, 11);
    send_frame(8'h1C, 1'b0, 11);
    wait_cyc(GAP + 100);
    chk("t2_pulses", pulses, 3);
    chk("t2_data", ps2dis_data, 8'h1C);
    chk("t2_pending", mq.size(), 0);
    wait_cyc(GAP + 100);

    send_frame(8'h1C, 1'b1, 11);
    err_exp++;
    wait_cyc(50);
    chk("t3_pulses", pulses, 3);
    chk("t3_ferrs", ferrs, 1);
    chk("t3_errcnt", err_cnt, 8'd1);
    send_frame(8'h16, 1'b0, 11);
    wait_cyc(50);
    chk("t3_data", ps2dis_data, 8'h16);
    chk("t3_pulses2", pulses, 4);
    wait_cyc(GAP + 100);

    send_frame(8'h00, 1'b0, 11);
    for (int k = 1; k <= 9; k++) send_frame(8'(k), 1'b0, 11);
    chk("t4_ovf", overflow, 1'b1);
    chk("t4_ovf_model", overflow, m_ovf);
    wait_cyc(9 * GAP + 500);
    chk("t4_ovf_sticky", overflow, 1'b1);
    chk("t4_pulses", pulses, 13);
    chk("t4_data", ps2dis_data, 8'h08);
    chk("t4_pending", mq.size(), 0);

    send_frame(8'h00, 1'b0, 5);
    err_exp++;
    wait_cyc(TMO + 50);
    chk("t5_ferrs", ferrs, err_exp);
    chk("t5_errcnt", err_cnt, 8'd2);
    chk("t5_pulses", pulses, 13);
    send_frame(8'h45, 1'b0, 11);
    wait_cyc(50);
    chk("t5_data", ps2dis_data, 8'h45);
    chk("t5_pulses2", pulses, 14);
    wait_cyc(GAP + 100);

    send_frame(8'h21, 1'b0, 11);
    send_frame(8'h22, 1'b0, 11);
    send_frame(8'h23, 1'b0, 11);
    send_frame(8'h99, 1'b0, 7);
    chk("t6_pulses", pulses, 15);
    chk("t6_held", mq.size(), 2);
    rst_n = 1'b0;
    mq.delete();
    m_last = 8'h00;
    m_ovf = 1'b0;
    err_exp = 0;
    #1;
    chk("t6_data0", ps2dis_data, 8'h00);
    chk("t6_flag0", ps2dis_recFlag, 1'b0);
    chk("t6_ovf0", overflow, 1'b0);
    chk("t6_ferr0", frame_err, 1'b0);
    chk("t6_errcnt0", err_cnt, 8'h00);
    ps2_clk = 1'b1;
    ps2_data = 1'b1;
    wait_cyc(3);
    rst_n = 1'b1;
    wait_cyc(GAP + 500);
    chk("t6_quiet", pulses, 15);
    chk("t6_ferrs", ferrs, 0);
    send_frame(8'h5A, 1'b0, 11);
    wait_cyc(50);
    chk("t6_data", ps2dis_data, 8'h5A);
    chk("t6_pulses2", pulses, 16);
    chk("t6_errcnt", err_cnt, 8'h00);
    chk("t6_ovf", overflow, m_ovf);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
